// File: rtl/bomb_pkg.sv
// Shared types, BCD limits and default parameters for the bomb countdown timer.
package bomb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_DEFUSED  = 3'd4,
    ST_EXPLODED = 3'd5
  } state_e;

  localparam logic [7:0] SEC_MAX_BCD = 8'h59;
  localparam logic [7:0] MIN_MAX_BCD = 8'h99;

  localparam int DEF_PENALTY_SEC = 10;
  localparam int DEF_WARN_SEC    = 10;
  localparam int DEF_MAX_STRIKES = 3;

  function automatic logic [6:0] bcd2bin(input logic [7:0] v);
    return 7'(v[7:4] * 10 + v[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] b);
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  function automatic logic bcd_time_valid(input logic [7:0] mn, input logic [7:0] sc);
    return (mn[7:4] <= 4'd9) && (mn[3:0] <= 4'd9) && (mn <= MIN_MAX_BCD) &&
           (sc[3:0] <= 4'd9) && (sc <= SEC_MAX_BCD) && ((mn | sc) != 8'h00);
  endfunction

endpackage

// File: rtl/bomb_countdown_if.sv
// Control and display bundle between the game logic and the countdown timer.
interface bomb_countdown_if;
  logic       tick;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic       defuse;
  logic       strike;
  logic       timer_en;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [2:0] state;
  logic [1:0] strikes;
  logic       warn;
  logic       exploded;
  logic       defused;
  logic       load_err;

  modport master (
    output tick, load, preset_min, preset_sec, start, pause, defuse, strike,
    input  timer_en, min_bcd, sec_bcd, state, strikes, warn, exploded, defused, load_err
  );

  modport slave (
    input  tick, load, preset_min, preset_sec, start, pause, defuse, strike,
    output timer_en, min_bcd, sec_bcd, state, strikes, warn, exploded, defused, load_err
  );
endinterface

// File: rtl/mmss_bcd_sub.sv
// Combinational mm:ss BCD minus binary seconds (0..60); at most one minute borrow.
module mmss_bcd_sub
  import bomb_pkg::*;
(
  input  logic [7:0] min_i,
  input  logic [7:0] sec_i,
  input  logic [5:0] sub_i,
  output logic [7:0] min_o,
  output logic [7:0] sec_o,
  output logic       uflow_o
);

  logic [6:0] min_b;
  logic [6:0] sec_b;
  logic [6:0] sub_b;
  logic [6:0] low_total;

  always_comb begin
    min_b = bcd2bin(min_i);
    sec_b = bcd2bin(sec_i);
    sub_b = {1'b0, sub_i};
    // Only totals below two minutes can be consumed by a subtrahend of at most 60.
    low_total = (min_b == 7'd1) ? sec_b + 7'd60 : sec_b;
    uflow_o   = (min_b < 7'd2) && (low_total <= sub_b);
    if (sec_b >= sub_b) begin
      sec_o = bin2bcd(sec_b - sub_b);
      min_o = min_i;
    end else begin
      sec_o = bin2bcd(sec_b + 7'd60 - sub_b);
      min_o = bin2bcd(min_b - 7'd1);
    end
  end

endmodule

// File: rtl/bomb_countdown.sv
// Bomb round FSM with BCD mm:ss countdown. Define BOMB_STRIKE_PENALTY_EN to make
// strikes also remove PENALTY_SEC seconds from the clock.
module bomb_countdown
  import bomb_pkg::*;
#(
  parameter int PENALTY_SEC = DEF_PENALTY_SEC,
  parameter int WARN_SEC    = DEF_WARN_SEC,
  parameter int MAX_STRIKES = DEF_MAX_STRIKES
) (
  input  logic             clk,
  input  logic             rst,
  bomb_countdown_if.slave  bus
);

`ifdef BOMB_STRIKE_PENALTY_EN
  localparam logic [5:0] STRIKE_SUB = 6'(PENALTY_SEC);
`else
  localparam logic [5:0] STRIKE_SUB = 6'(PENALTY_SEC) & 6'd0;
`endif
  localparam logic [1:0] MAX_ST  = 2'(MAX_STRIKES);
  localparam logic [6:0] WARN_LIM = 7'(WARN_SEC);

  state_e     state_q, state_d;
  logic [7:0] min_q, min_d, sec_q, sec_d;
  logic [1:0] strikes_q, strikes_d;
  logic       timer_en_q, warn_q, warn_d, exploded_q, defused_q;
  logic       load_err_q, load_err_d;
  logic       tick_run, load_ok, uflow;
  logic [5:0] sub_val;
  logic [7:0] res_min, res_sec;

  assign tick_run = bus.tick && (state_q == ST_RUNNING);
  assign sub_val  = (bus.strike ? STRIKE_SUB : 6'd0) + {5'd0, tick_run};
  assign load_ok  = bcd_time_valid(bus.preset_min, bus.preset_sec);

  mmss_bcd_sub u_sub (
    .min_i   (min_q),
    .sec_i   (sec_q),
    .sub_i   (sub_val),
    .min_o   (res_min),
    .sec_o   (res_sec),
    .uflow_o (uflow)
  );

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    strikes_d  = strikes_q;
    load_err_d = 1'b0;
    warn_d     = (state_q == ST_RUNNING) && (min_q == 8'h00) && (bcd2bin(sec_q) <= WARN_LIM);
    case (state_q)
      ST_IDLE, ST_ARMED: begin
        if (bus.load) begin
          if (load_ok) begin
            state_d = ST_ARMED;
            min_d   = bus.preset_min;
            sec_d   = bus.preset_sec;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (state_q == ST_ARMED && bus.start) begin
          state_d = ST_RUNNING;
        end
      end
      ST_RUNNING, ST_PAUSED: begin
        if (bus.defuse) begin
          state_d = ST_DEFUSED;
        end else if (bus.strike || tick_run) begin
          // Strike and tick land together; time saturates at 00:00 rather than wrapping.
          strikes_d = strikes_q + {1'b0, bus.strike};
          if (sub_val != 6'd0) begin
            if (uflow) begin
              min_d   = 8'h00;
              sec_d   = 8'h00;
              state_d = ST_EXPLODED;
            end else begin
              min_d = res_min;
              sec_d = res_sec;
            end
          end
          if (strikes_d >= MAX_ST) state_d = ST_EXPLODED;
        end else if (state_q == ST_RUNNING && bus.pause) begin
          state_d = ST_PAUSED;
        end else if (state_q == ST_PAUSED && bus.start) begin
          state_d = ST_RUNNING;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
      strikes_q  <= 2'd0;
      timer_en_q <= 1'b0;
      warn_q     <= 1'b0;
      exploded_q <= 1'b0;
      defused_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      strikes_q  <= strikes_d;
      timer_en_q <= (state_d == ST_RUNNING);
      warn_q     <= warn_d;
      exploded_q <= (state_d == ST_EXPLODED);
      defused_q  <= (state_d == ST_DEFUSED);
      load_err_q <= load_err_d;
    end
  end

  assign bus.state    = state_q;
  assign bus.min_bcd  = min_q;
  assign bus.sec_bcd  = sec_q;
  assign bus.strikes  = strikes_q;
  assign bus.timer_en = timer_en_q;
  assign bus.warn     = warn_q;
  assign bus.exploded = exploded_q;
  assign bus.defused  = defused_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bomb_countdown.sv
// Self-checking bench for bomb_countdown: directed table, corner sequences, random vs model.
module tb_bomb_countdown;

  localparam int PEN  = 10;
  localparam int WARN = 10;
  localparam int MAXS = 3;
`ifdef BOMB_STRIKE_PENALTY_EN
  localparam int STRIKE_SEC = PEN;
`else
  localparam int STRIKE_SEC = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bomb_countdown_if bus_if ();

  bomb_countdown #(.PENALTY_SEC(PEN), .WARN_SEC(WARN), .MAX_STRIKES(MAXS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: remaining time as whole seconds, state as plain integer code.
  int m_state, m_rem, m_strikes;
  logic m_warn, m_lerr;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic model_reset();
    m_state = 0; m_rem = 0; m_strikes = 0; m_warn = 1'b0; m_lerr = 1'b0;
  endtask

  task automatic model_step(input logic tk, ld, input logic [7:0] pm, ps,
                            input logic sa, pa, df, sk);
    int s;
    bit ok;
    m_warn = (m_state == 2) && (m_rem <= WARN);
    m_lerr = 1'b0;
    if (m_state == 0 || m_state == 1) begin
      if (ld) begin
        ok = (pm[7:4] <= 9) && (pm[3:0] <= 9) && (ps[7:4] <= 5) && (ps[3:0] <= 9) &&
             !(pm == 8'h00 && ps == 8'h00);
        if (ok) begin
          m_state = 1;
          m_rem = bcd_val(pm) * 60 + bcd_val(ps);
        end else m_lerr = 1'b1;
      end else if (m_state == 1 && sa) m_state = 2;
    end else if (m_state == 2 || m_state == 3) begin
      if (df) m_state = 4;
      else if (sk || (tk && m_state == 2)) begin
        s = (sk ? STRIKE_SEC : 0) + ((tk && m_state == 2) ? 1 : 0);
        if (sk) m_strikes++;
        if (s > 0) begin
          if (m_rem <= s) begin m_rem = 0; m_state = 5; end
          else m_rem -= s;
        end
        if (m_strikes >= MAXS) m_state = 5;
      end else if (m_state == 2 && pa) m_state = 3;
      else if (m_state == 3 && sa) m_state = 2;
    end
  endtask

  task automatic mcheck(input string nm);
    logic [26:0] got, exp;
    got = {bus_if.state, bus_if.min_bcd, bus_if.sec_bcd, bus_if.strikes, bus_if.timer_en,
           bus_if.warn, bus_if.exploded, bus_if.defused, bus_if.load_err};
    exp = {3'(m_state), to_bcd(m_rem / 60), to_bcd(m_rem % 60), 2'(m_strikes),
           m_state == 2, m_warn, m_state == 5, m_state == 4, m_lerr};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d %h:%h stk=%0d en/wr/ex/df/le=%b, expected st=%0d %h:%h stk=%0d en/wr/ex/df/le=%b",
               nm, got[26:24], got[23:16], got[15:8], got[7:6], got[4:0],
               exp[26:24], exp[23:16], exp[15:8], exp[7:6], exp[4:0]);
    end
  endtask

  task automatic expect_eq(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step(input logic tk, ld, input logic [7:0] pm, ps,
                      input logic sa, pa, df, sk);
    bus_if.tick = tk; bus_if.load = ld; bus_if.preset_min = pm; bus_if.preset_sec = ps;
    bus_if.start = sa; bus_if.pause = pa; bus_if.defuse = df; bus_if.strike = sk;
    @(posedge clk);
    #1;
    model_step(tk, ld, pm, ps, sa, pa, df, sk);
  endtask

  task automatic idle1();  step(0, 0, 8'h00, 8'h00, 0, 0, 0, 0); endtask
  task automatic tick1();  step(1, 0, 8'h00, 8'h00, 0, 0, 0, 0); endtask
  task automatic start1(); step(0, 0, 8'h00, 8'h00, 1, 0, 0, 0); endtask
  task automatic load1(input logic [7:0] pm, ps); step(0, 1, pm, ps, 0, 0, 0, 0); endtask

  task automatic do_reset(input string nm);
    bus_if.tick = 0; bus_if.load = 0; bus_if.start = 0; bus_if.pause = 0;
    bus_if.defuse = 0; bus_if.strike = 0;
    rst = 1'b1;
    #2;
    model_reset();
    mcheck(nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       tk, ld, sa, pa;
    logic [7:0] pm, ps;
    logic [2:0] st;
    logic [7:0] mn, sc;
    logic       ten, lerr;
  } vec_t;

  vec_t tv[15];

  function automatic vec_t mkv(input logic tk, ld, sa, pa, input logic [7:0] pm, ps,
                               input logic [2:0] st, input logic [7:0] mn, sc,
                               input logic ten, lerr);
    vec_t v;
    v.tk = tk; v.ld = ld; v.sa = sa; v.pa = pa; v.pm = pm; v.ps = ps;
    v.st = st; v.mn = mn; v.sc = sc; v.ten = ten; v.lerr = lerr;
    return v;
  endfunction

  initial begin
    logic [7:0] rpm, rps;
    bus_if.tick = 0; bus_if.load = 0; bus_if.start = 0; bus_if.pause = 0;
    bus_if.defuse = 0; bus_if.strike = 0; bus_if.preset_min = 0; bus_if.preset_sec = 0;

    //            tk ld sa pa  pm     ps     st  mn     sc    en le
    tv[0]  = mkv(0, 1, 0, 0, 8'h00, 8'h5A, 0, 8'h00, 8'h00, 0, 1);
    tv[1]  = mkv(0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    tv[2]  = mkv(0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1);
    tv[3]  = mkv(0, 1, 0, 0, 8'h0A, 8'h00, 0, 8'h00, 8'h00, 0, 1);
    tv[4]  = mkv(0, 1, 0, 0, 8'h01, 8'h00, 1, 8'h01, 8'h00, 0, 0);
    tv[5]  = mkv(1, 0, 0, 0, 8'h00, 8'h00, 1, 8'h01, 8'h00, 0, 0);
    tv[6]  = mkv(0, 0, 1, 0, 8'h00, 8'h00, 2, 8'h01, 8'h00, 1, 0);
    tv[7]  = mkv(1, 0, 0, 0, 8'h00, 8'h00, 2, 8'h00, 8'h59, 1, 0);
    tv[8]  = mkv(1, 0, 0, 0, 8'h00, 8'h00, 2, 8'h00, 8'h58, 1, 0);
    tv[9]  = mkv(1, 0, 0, 0, 8'h00, 8'h00, 2, 8'h00, 8'h57, 1, 0);
    tv[10] = mkv(0, 1, 0, 0, 8'h02, 8'h00, 2, 8'h00, 8'h57, 1, 0);
    tv[11] = mkv(0, 0, 0, 1, 8'h00, 8'h00, 3, 8'h00, 8'h57, 0, 0);
    tv[12] = mkv(1, 0, 0, 0, 8'h00, 8'h00, 3, 8'h00, 8'h57, 0, 0);
    tv[13] = mkv(0, 0, 1, 0, 8'h00, 8'h00, 2, 8'h00, 8'h57, 1, 0);
    tv[14] = mkv(1, 0, 0, 0, 8'h00, 8'h00, 2, 8'h00, 8'h56, 1, 0);

    #3;
    model_reset();
    mcheck("reset_initial");
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      logic [19:0] got, exp;
      step(tv[i].tk, tv[i].ld, tv[i].pm, tv[i].ps, tv[i].sa, tv[i].pa, 0, 0);
      got = {bus_if.state, bus_if.min_bcd, bus_if.sec_bcd, bus_if.timer_en};
      exp = {tv[i].st, tv[i].mn, tv[i].sc, tv[i].ten};
      n_vec++;
      if (got !== exp || bus_if.load_err !== tv[i].lerr) begin
        n_bad++;
        $display("FAIL table[%0d]: got st=%0d %h:%h en=%b le=%b expected st=%0d %h:%h en=%b le=%b",
                 i, got[19:17], got[16:9], got[8:1], got[0], bus_if.load_err,
                 exp[19:17], exp[16:9], exp[8:1], exp[0], tv[i].lerr);
      end
      mcheck($sformatf("table_model[%0d]", i));
    end
    expect_eq("table_warn_low", int'(bus_if.warn), 0);

    // Timeout at 00:00, then a dead tick.
    do_reset("reset_mid_table");
    load1(8'h00, 8'h02); start1(); tick1();
    expect_eq("expl_first_tick_sec", bus_if.sec_bcd, 8'h01);
    tick1();
    expect_eq("expl_state", bus_if.state, 5);
    expect_eq("expl_time", {bus_if.min_bcd, bus_if.sec_bcd}, 16'h0000);
    expect_eq("expl_en_flag", {bus_if.timer_en, bus_if.exploded}, 2'b01);
    tick1();
    mcheck("expl_after_tick");
    expect_eq("expl_hold", {bus_if.state, bus_if.min_bcd, bus_if.sec_bcd}, {3'd5, 16'h0000});

    // Defuse beats a final tick; time keeps its pre-tick value.
    do_reset("reset_defuse");
    load1(8'h00, 8'h01); start1();
    step(1, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    expect_eq("defuse_state", bus_if.state, 4);
    expect_eq("defuse_time", {bus_if.min_bcd, bus_if.sec_bcd}, 16'h0001);
    expect_eq("defuse_flag", {bus_if.defused, bus_if.exploded}, 2'b10);

    // Strikes with or without time penalty.
    do_reset("reset_strike");
    load1(8'h00, 8'h15); start1();
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
`ifdef BOMB_STRIKE_PENALTY_EN
    expect_eq("strike_time", bus_if.sec_bcd, 8'h05);
    idle1();
    expect_eq("strike_warn", bus_if.warn, 1);
`else
    expect_eq("strike_time", bus_if.sec_bcd, 8'h15);
    idle1();
    expect_eq("strike_warn", bus_if.warn, 0);
`endif
    expect_eq("strike_count", bus_if.strikes, 1);
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    mcheck("strike_second");
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    expect_eq("strike_explode", bus_if.state, 5);
`ifdef BOMB_STRIKE_PENALTY_EN
    expect_eq("strike_final_count", bus_if.strikes, 2);
`else
    expect_eq("strike_final_count", bus_if.strikes, 3);
`endif

    // Strike and tick in one cycle.
    do_reset("reset_strike_tick");
    load1(8'h01, 8'h05); start1();
    step(1, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    expect_eq("strike_tick_time", {bus_if.min_bcd, bus_if.sec_bcd},
              {to_bcd((65 - STRIKE_SEC - 1) / 60), to_bcd((65 - STRIKE_SEC - 1) % 60)});

    // Pause freezes; resume counts; async reset needs no edge.
    do_reset("reset_pause");
    load1(8'h00, 8'h30); start1(); tick1();
    step(0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick1();
    expect_eq("pause_hold", {bus_if.state, bus_if.sec_bcd, 7'(bus_if.timer_en)}, {3'd3, 8'h29, 7'd0});
    start1(); tick1();
    expect_eq("resume_dec", bus_if.sec_bcd, 8'h28);
    rst = 1'b1;
    #2;
    expect_eq("async_rst", {bus_if.state, bus_if.min_bcd, bus_if.sec_bcd, bus_if.timer_en}, 0);
    model_reset();
    @(posedge clk); #1; rst = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      if (m_state >= 4 || $urandom_range(0, 299) == 0) begin
        do_reset("rand_reset");
      end else begin
        if ($urandom_range(0, 9) < 7) begin
          rpm = to_bcd($urandom_range(0, 2));
          rps = to_bcd($urandom_range(0, 59));
        end else begin
          rpm = 8'($urandom); rps = 8'($urandom);
        end
        step($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, rpm, rps,
             $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
        mcheck($sformatf("rand[%0d]", c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
